// File: rtl/id_ex_issue.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_issue
//  Purpose  : ID/EX issue register. Captures a decoded instruction into the
//             execute stage, resolves source operands (forwarding from EX,
//             MEM and WB when FORWARD_EN is defined), and detects the hazards
//             that must hold decode back for a cycle.
//  Config   : `define FORWARD_EN -> operand forwarding + load-use-only hazard.
//             Undefined (default) -> no forwarding; decode stalls while any
//             in-flight writer (EX, MEM, WB) targets one of its sources.
//  Ports    : clk, rst                      clock, sync active-high reset
//             id_valid, id_rs1/rs2/rd       decode instruction and registers
//             id_rs1_val/rs2_val/imm        register-file reads, immediate
//             id_use_imm                    b from immediate, rs2 unused
//             id_ALUOp/regwrite/memread     decoded controls
//             id_ready (out)                decode instruction accepted
//             flush, ex_stall               squash EX slot / hold EX slot
//             alu_out, mem_*, wb_*          forwarding sources
//             ex_valid, a, b, ALUOp, ex_rd,
//             ex_regwrite, ex_memread (out) registered execute-stage inputs
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_issue #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic [4:0]    id_rd,
  input  logic [DW-1:0] id_rs1_val,
  input  logic [DW-1:0] id_rs2_val,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [5:0]    id_ALUOp,
  input  logic          id_regwrite,
  input  logic          id_memread,
  output logic          id_ready,
  input  logic          flush,
  input  logic          ex_stall,
  input  logic [DW-1:0] alu_out,
  input  logic [4:0]    mem_rd,
  input  logic          mem_regwrite,
  input  logic [DW-1:0] mem_result,
  input  logic [4:0]    wb_rd,
  input  logic          wb_regwrite,
  input  logic [DW-1:0] wb_result,
  output logic          ex_valid,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [5:0]    ALUOp,
  output logic [4:0]    ex_rd,
  output logic          ex_regwrite,
  output logic          ex_memread
);

  logic          w_hazard;
  logic [DW-1:0] w_a_next;
  logic [DW-1:0] w_b_next;

`ifdef FORWARD_EN
  // EX can forward only a computed value; a load's data is not ready yet.
  logic w_ex_fwd_ok;
  logic w_rs1_ex, w_rs1_mem, w_rs1_wb;
  logic w_rs2_ex, w_rs2_mem, w_rs2_wb;

  assign w_ex_fwd_ok = ex_valid & ex_regwrite & ~ex_memread;

  assign w_rs1_ex  = (id_rs1 != 5'd0) & w_ex_fwd_ok  & (ex_rd  == id_rs1);
  assign w_rs1_mem = (id_rs1 != 5'd0) & mem_regwrite & (mem_rd == id_rs1);
  assign w_rs1_wb  = (id_rs1 != 5'd0) & wb_regwrite  & (wb_rd  == id_rs1);
  assign w_rs2_ex  = (id_rs2 != 5'd0) & w_ex_fwd_ok  & (ex_rd  == id_rs2);
  assign w_rs2_mem = (id_rs2 != 5'd0) & mem_regwrite & (mem_rd == id_rs2);
  assign w_rs2_wb  = (id_rs2 != 5'd0) & wb_regwrite  & (wb_rd  == id_rs2);

  // Youngest producer wins.
  always_comb begin
    w_a_next = id_rs1_val;
    if (w_rs1_ex)       w_a_next = alu_out;
    else if (w_rs1_mem) w_a_next = mem_result;
    else if (w_rs1_wb)  w_a_next = wb_result;

    w_b_next = id_rs2_val;
    if (id_use_imm)     w_b_next = id_imm;
    else if (w_rs2_ex)  w_b_next = alu_out;
    else if (w_rs2_mem) w_b_next = mem_result;
    else if (w_rs2_wb)  w_b_next = wb_result;
  end

  // Only a load in EX cannot be forwarded in time.
  assign w_hazard = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (~id_use_imm & (ex_rd == id_rs2)));
`else
  logic w_rs1_busy;
  logic w_rs2_busy;
  logic w_unused_fwd;

  // Any writer still in flight for a source register blocks issue until it
  // has retired, since the register file read would be stale.
  assign w_rs1_busy = (id_rs1 != 5'd0) &
                      ((ex_valid & ex_regwrite & (ex_rd == id_rs1)) |
                       (mem_regwrite & (mem_rd == id_rs1)) |
                       (wb_regwrite  & (wb_rd  == id_rs1)));
  assign w_rs2_busy = (id_rs2 != 5'd0) &
                      ((ex_valid & ex_regwrite & (ex_rd == id_rs2)) |
                       (mem_regwrite & (mem_rd == id_rs2)) |
                       (wb_regwrite  & (wb_rd  == id_rs2)));

  assign w_hazard = id_valid & (w_rs1_busy | (~id_use_imm & w_rs2_busy));

  assign w_a_next = id_rs1_val;
  assign w_b_next = id_use_imm ? id_imm : id_rs2_val;

  // Forwarded data buses are not consumed in this build.
  assign w_unused_fwd = ^{alu_out, mem_result, wb_result};
`endif

  // Flush takes the decode instruction (it is being squashed upstream too).
  assign id_ready = ~rst & (flush | (~ex_stall & ~w_hazard));

  always_ff @(posedge clk) begin
    if (rst || flush || (!ex_stall && (w_hazard || !id_valid))) begin
      ex_valid    <= 1'b0;
      a           <= '0;
      b           <= '0;
      ALUOp       <= '0;
      ex_rd       <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid    <= 1'b1;
      a           <= w_a_next;
      b           <= w_b_next;
      ALUOp       <= id_ALUOp;
      ex_rd       <= id_rd;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_issue
//  Purpose  : Self-checking bench for id_ex_issue: directed scenarios plus
//             randomized traffic compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_issue;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, id_valid, id_use_imm, id_regwrite, id_memread;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm, alu_out, mem_result, wb_result;
  logic [5:0]  id_ALUOp;
  logic        flush, ex_stall, mem_regwrite, wb_regwrite;
  logic        id_ready, ex_valid, ex_regwrite, ex_memread;
  logic [31:0] a, b;
  logic [5:0]  ALUOp;
  logic [4:0]  ex_rd;

  id_ex_issue #(.DW(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_ALUOp(id_ALUOp),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ready(id_ready),
    .flush(flush), .ex_stall(ex_stall), .alu_out(alu_out), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_result(mem_result), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .wb_result(wb_result), .ex_valid(ex_valid),
    .a(a), .b(b), .ALUOp(ALUOp), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the execute-stage slot
  logic        m_valid, m_rw, m_mr;
  logic [31:0] m_a, m_b;
  logic [5:0]  m_op;
  logic [4:0]  m_rd;
  logic        pipe;       // MEM/WB follow the model's EX slot when set
  logic        last_ready; // id_ready as observed in the latest step

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Does an in-flight writer (EX, MEM or WB) target register r?
  function automatic bit pending_write(input logic [4:0] r);
    return (r != 5'd0) && ((m_valid && m_rw && m_rd == r) ||
                           (mem_regwrite && mem_rd == r) ||
                           (wb_regwrite && wb_rd == r));
  endfunction

  // Value an operand register should read after forwarding.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] v);
    if (!FWD || r == 5'd0) return v;
    if (m_valid && m_rw && !m_mr && m_rd == r) return alu_out;
    if (mem_regwrite && mem_rd == r) return mem_result;
    if (wb_regwrite && wb_rd == r) return wb_result;
    return v;
  endfunction

  // One clock: check id_ready before the edge, outputs after it.
  task automatic step();
    bit          haz, exp_ready;
    logic        o_valid, o_rw;
    logic [4:0]  o_rd;
    #1;
    if (FWD)
      haz = id_valid && m_valid && m_mr && m_rd != 5'd0 &&
            (m_rd == id_rs1 || (!id_use_imm && m_rd == id_rs2));
    else
      haz = id_valid && (pending_write(id_rs1) || (!id_use_imm && pending_write(id_rs2)));
    exp_ready = rst ? 1'b0 : flush ? 1'b1 : (ex_stall || haz) ? 1'b0 : 1'b1;
    last_ready = id_ready;
    check("id_ready", 64'(id_ready), 64'(exp_ready));
    o_valid = m_valid; o_rw = m_rw; o_rd = m_rd;
    if (rst || flush || (!ex_stall && (haz || !id_valid))) begin
      {m_valid, m_rw, m_mr, m_a, m_b, m_op, m_rd} = '0;
    end else if (!ex_stall) begin
      m_valid = 1'b1;
      m_a  = operand(id_rs1, id_rs1_val);
      m_b  = id_use_imm ? id_imm : operand(id_rs2, id_rs2_val);
      m_op = id_ALUOp; m_rd = id_rd; m_rw = id_regwrite; m_mr = id_memread;
    end
    @(posedge clk);
    #1;
    if (pipe) begin
      wb_rd = mem_rd; wb_regwrite = mem_regwrite; wb_result = $urandom;
      mem_rd = o_rd; mem_regwrite = o_valid & o_rw; mem_result = $urandom;
    end
    check("ex_valid", 64'(ex_valid), 64'(m_valid));
    check("a", 64'(a), 64'(m_a));
    check("b", 64'(b), 64'(m_b));
    check("ALUOp", 64'(ALUOp), 64'(m_op));
    check("ex_rd", 64'(ex_rd), 64'(m_rd));
    check("ex_regwrite", 64'(ex_regwrite), 64'(m_rw));
    check("ex_memread", 64'(ex_memread), 64'(m_mr));
  endtask

  task automatic set_instr(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                           input logic ui, input logic rw, input logic mr);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_rs1_val = v1;
    id_rs2_val = v2; id_imm = 32'h0000_0ABC; id_use_imm = ui;
    id_ALUOp = 6'h21; id_regwrite = rw; id_memread = mr;
  endtask

  task automatic clear_fwd();
    mem_rd = '0; mem_regwrite = 1'b0; mem_result = '0;
    wb_rd = '0; wb_regwrite = 1'b0; wb_result = '0; alu_out = '0;
  endtask

  initial begin
    int stalls;
    {m_valid, m_rw, m_mr, m_a, m_b, m_op, m_rd} = '0;
    pipe = 1'b0; last_ready = 1'b0;
    flush = 1'b0; ex_stall = 1'b0;
    clear_fwd();
    set_instr(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 1'b0, 1'b1, 1'b0);

    // Reset held two cycles with a valid instruction presented
    rst = 1'b1;
    step(); step();
    check("reset_ex_valid", 64'(ex_valid), 64'd0);
    check("reset_ab", 64'({a, b}), 64'd0);
    rst = 1'b0;

    // Stall hold: capture, then three cycles of ex_stall
    set_instr(1'b1, 5'd9, 5'd10, 5'd11, 32'hCAFE, 32'hBEEF, 1'b0, 1'b1, 1'b0);
    step();
    ex_stall = 1'b1;
    set_instr(1'b1, 5'd12, 5'd13, 5'd14, 32'h1, 32'h2, 1'b0, 1'b1, 1'b0);
    step(); step(); step();
    check("stall_hold_a", 64'(a), 64'hCAFE);
    // flush together with ex_stall loads a bubble
    flush = 1'b1;
    step();
    flush = 1'b0; ex_stall = 1'b0;
    check("flush_stall_bubble", 64'(ex_valid), 64'd0);

`ifdef FORWARD_EN
    // EX forwarding of an ALU result
    set_instr(1'b1, 5'd1, 5'd0, 5'd3, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    alu_out = 32'h10;
    set_instr(1'b1, 5'd3, 5'd0, 5'd6, 32'h5, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    check("ex_fwd_a", 64'(a), 64'h10);
    // EX > MEM > WB priority on rs2, and r0 never forwarded
    set_instr(1'b1, 5'd1, 5'd0, 5'd4, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    alu_out = 32'd1; mem_rd = 5'd4; mem_regwrite = 1'b1; mem_result = 32'd2;
    wb_rd = 5'd4; wb_regwrite = 1'b1; wb_result = 32'd3;
    set_instr(1'b1, 5'd1, 5'd4, 5'd8, 32'h7, 32'h77, 1'b0, 1'b0, 1'b0);
    step();
    check("prio_b", 64'(b), 64'd1);
    set_instr(1'b1, 5'd1, 5'd0, 5'd8, 32'h7, 32'h55, 1'b0, 1'b0, 1'b0);
    step();
    check("r0_b", 64'(b), 64'h55);
    clear_fwd();
    step();
    // Load-use: one stall, then MEM forwarding of the load result
    pipe = 1'b1;
    set_instr(1'b1, 5'd1, 5'd0, 5'd7, 32'h1, 32'h0, 1'b1, 1'b1, 1'b1);
    step();
    set_instr(1'b1, 5'd7, 5'd0, 5'd9, 32'h99, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    check("load_use_stall", 64'(last_ready), 64'd0);
    step();
    check("load_use_capture", 64'(last_ready), 64'd1);
    pipe = 1'b0;
    clear_fwd();
`else
    // No forwarding: writer of r5 must drain through EX, MEM and WB
    pipe = 1'b1;
    set_instr(1'b1, 5'd1, 5'd0, 5'd5, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    set_instr(1'b1, 5'd5, 5'd0, 5'd6, 32'h5A5A, 32'h0, 1'b1, 1'b1, 1'b0);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_ready) break;
      stalls++;
    end
    check("nofwd_stall_cycles", 64'(stalls), 64'd3);
    check("nofwd_a", 64'(a), 64'h5A5A);
    pipe = 1'b0;
    clear_fwd();
`endif

    // Randomized traffic; odd segments let MEM/WB trail the EX slot
    for (int i = 0; i < 1600; i++) begin
      pipe = ((i / 400) % 2) == 1;
      rst = $urandom_range(0, 99) < 2;
      flush = $urandom_range(0, 99) < 8;
      ex_stall = $urandom_range(0, 99) < 12;
      id_valid = $urandom_range(0, 3) != 0;
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_rs1_val = $urandom; id_rs2_val = $urandom; id_imm = $urandom;
      id_use_imm = 1'($urandom_range(0, 1));
      id_ALUOp = 6'($urandom_range(0, 63));
      id_regwrite = 1'($urandom_range(0, 1));
      id_memread = $urandom_range(0, 3) == 0;
      alu_out = $urandom;
      if (!pipe) begin
        mem_rd = 5'($urandom_range(0, 7)); mem_regwrite = 1'($urandom_range(0, 1));
        mem_result = $urandom;
        wb_rd = 5'($urandom_range(0, 7)); wb_regwrite = 1'($urandom_range(0, 1));
        wb_result = $urandom;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_issue.md
ID_EX_ISSUE -- requirements
Module: id_ex_issue

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width of all operand/result buses.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port id_valid  input  1  decode stage presents an instruction.
REQ-005 SHALL have ports id_rs1, id_rs2, id_rd  input  5 each  source/destination register numbers.
REQ-006 SHALL have ports id_rs1_val, id_rs2_val, id_imm  input  DW each  register-file reads and immediate.
REQ-007 SHALL have port id_use_imm  input  1  b operand taken from id_imm; rs2 not a source.
REQ-008 SHALL have ports id_ALUOp (input 6), id_regwrite (input 1), id_memread (input 1)  decoded controls.
REQ-009 SHALL have port id_ready  output  1  combinational; decode instruction accepted this cycle.
REQ-010 SHALL have ports flush (input 1, squash EX slot) and ex_stall (input 1, downstream hold).
REQ-011 SHALL have ports alu_out (input DW), mem_rd/mem_regwrite/mem_result, wb_rd/wb_regwrite/wb_result  forwarding sources (5/1/DW).
REQ-012 SHALL have registered outputs ex_valid (1), a (DW), b (DW), ALUOp (6), ex_rd (5), ex_regwrite (1), ex_memread (1) driving the execute stage.

Function
REQ-013 Per-cycle priority SHALL be: rst > flush > ex_stall > hazard > capture.
REQ-014 Flush SHALL load a bubble next edge: ex_valid, a, b, ALUOp, ex_rd, ex_regwrite, ex_memread all 0.
REQ-015 ex_stall (no flush) SHALL hold every output register unchanged and force id_ready=0.
REQ-016 Load-use hazard SHALL be: id_valid & ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | (!id_use_imm & ex_rd==id_rs2)).
REQ-017 On hazard (no flush/ex_stall) id_ready SHALL be 0 and a bubble SHALL be loaded; instruction re-presented next cycle.
REQ-018 Otherwise id_ready SHALL be 1; if id_valid, operands/controls captured with ex_valid=1, else bubble loaded.
REQ-019 Operand forwarding priority SHALL be: EX (alu_out, when ex_valid & ex_regwrite & !ex_memread) > MEM > WB > register file.
REQ-020 A source SHALL match only when its regwrite=1 and its rd equals the operand register and rd!=0; r0 always reads id value.
REQ-021 b SHALL equal id_imm when id_use_imm=1, with no forwarding applied to b.
REQ-022 Latency SHALL be one cycle from accepted instruction to a/b/ALUOp valid at outputs.
REQ-023 flush with id_valid SHALL still assert id_ready=1 and discard the decode instruction (upstream also flushed).

Reset
REQ-024 rst=1 SHALL load the bubble state of REQ-014 at the next edge regardless of other inputs.
REQ-025 During rst id_ready SHALL be 0; any in-flight instruction SHALL be dropped.

Configuration
REQ-026 Macro FORWARD_EN SHALL enable REQ-019/REQ-020 forwarding and the REQ-016 hazard rule.
REQ-027 Without FORWARD_EN: no forwarding; hazard SHALL be any source register matching rd (rd!=0, regwrite=1) of a valid EX, MEM or WB writer; a/b SHALL be taken directly from id values.

Verification
REQ-028 Reset: rst=1 for 2 cycles with id_valid=1 -> ex_valid=0, a=b=0, ALUOp=0, id_ready=0.
REQ-029 EX forward: EX holds ADD rd=3 alu_out=0x10, decode rs1=3 val 0x5 -> next cycle a=0x10.
REQ-030 Priority: EX rd=4 alu_out=1, MEM rd=4 result=2, WB rd=4 result=3, rs2=4 -> b=1; same with rs2=0 -> b=id_rs2_val.
REQ-031 Load-use: EX memread rd=7, decode rs1=7 -> id_ready=0 one cycle, bubble, then capture with MEM forwarding.
REQ-032 flush and ex_stall same cycle -> bubble loaded; ex_stall alone 3 cycles -> outputs constant, id_ready=0.
REQ-033 FORWARD_EN undefined: writer rd=5 in EX, decode rs1=5 -> 3 stall cycles before capture with a=id_rs1_val.
